loop_index_counter: RTL
=======================

// Module: loop_index_counter
// PURPOSE
//   Parametrised nested-loop index generator for the matrix-multiply datapath.
//   It chains NUM_LEVELS counters of CNT_WIDTH bits, level 0 innermost, with a per-level terminal value latched at START.
//   It replaces hand-wired counter cascades and carry logic, and adds start/done sequencing, stall control,
//   runtime loop bounds and a last-tuple flag. It drives row/column/k addressing of the operand buffers.
// PARAMETERS
//   NUM_LEVELS  3  number of nested loop levels (>=1); level 0 innermost
//   CNT_WIDTH   4  bits per level index; also width of each level's limit
// PORTS
//   CLK    in   1                      system clock, rising edge
//   RST    in   1                      asynchronous, active-low reset
//   CLR    in   1                      synchronous clear/abort, active-high
//   START  in   1                      start a loop sweep; sampled only in IDLE
//   CE     in   1                      advance enable; 0 = stall, current tuple held
//   LIMIT  in   NUM_LEVELS*CNT_WIDTH   per-level terminal index; level i = [i*CNT_WIDTH +: CNT_WIDTH]
//   BUSY   out  1                      sweep in progress (RUN or DONE state)
//   VALID  out  1                      IDX holds a valid tuple (RUN state)
//   IDX    out  NUM_LEVELS*CNT_WIDTH   current index tuple, same packing as LIMIT
//   WRAP   out  NUM_LEVELS             WRAP[i]=1: level i wraps on this advance
//   LAST   out  1                      current tuple is the final one
//   DONE   out  1                      one-cycle pulse after the final tuple is consumed
// BEHAVIOUR
//   - Reset (RST=0, async): state=IDLE, IDX=0, latched limits=0, all outputs 0. Outputs go to 0 immediately, without a clock edge.
//   - States: IDLE, RUN, DONE.
//   - IDLE -> RUN: on START=1. LIMIT is latched into internal limit regs and IDX is loaded with 0.
//     First VALID occurs on the cycle after START (latency 1).
//   - RUN: VALID=1, BUSY=1. When CE=1, the tuple advances one step:
//     - Level 0 increments.
//     - Level i wraps to 0 when it equals its limit and all levels below it are at their limits.
//       On wrap, it carries into level i+1.
//     - Levels not receiving a carry hold their value. When CE=0, all levels hold.
//   - WRAP[i] = VALID & CE & (levels 0..i all at their limits). It is combinational and acts as the carry-out.
//   - LAST = VALID & (all levels at their limits). It is independent of CE.
//   - RUN -> DONE: on CE=1 while LAST=1. At the same edge IDX is loaded with 0.
//   - DONE: lasts exactly 1 cycle, with DONE=1, BUSY=1, VALID=0. Then the block returns to IDLE.
//   - Tuple count per sweep = product over i of (limit_i + 1). The index never exceeds its latched limit, so there is no
//     width overflow. A limit of 2^CNT_WIDTH-1 gives a full binary wrap.
//   - A limit of 0 on a level holds that level at 0; it wraps on every advance.
//     If all limits are 0: a single tuple is produced, with LAST=1 on the first VALID cycle.
//   - START in RUN or DONE is ignored; no restart occurs. Back-to-back sweeps: START is accepted in the IDLE cycle after DONE.
//   - LIMIT changes after START have no effect until the next accepted START.
//   - CE in IDLE or DONE is ignored.
//   - CLR=1 at a clock edge, from any state: IDLE, IDX=0, no DONE pulse. CLR has priority over START and CE.
//   - RST asserted mid-sweep aborts the sweep the same way, asynchronously. No DONE pulse is generated.
//   - All outputs other than WRAP and LAST are registered or decoded from state; there are no combinational paths from LIMIT.
// TESTING
//   1. NUM_LEVELS=3, CNT_WIDTH=4, LIMIT={1,2,3} (lvl2,lvl1,lvl0), START then CE=1 held:
//      - 24 VALID cycles in the order (0,0,0),(0,0,1)...(1,2,3).
//      - WRAP[0] fires every 4th tuple and WRAP[1] every 12th.
//      - LAST=1 and WRAP=3'b111 on tuple 24.
//      - DONE pulses 1 cycle later, then BUSY=0.
//   2. Same limits, CE toggling 1,0,1,0:
//      - Same 24-tuple sequence over 48 RUN cycles.
//      - IDX is held and WRAP=0 on CE=0 cycles.
//      - LAST stays high across a stall cycle.
//   3. LIMIT=0 on all levels:
//      - Exactly 1 VALID cycle with IDX=0, LAST=1, WRAP=3'b111 (with CE=1).
//      - DONE on the next cycle.
//   4. LIMIT=15 on all levels, CE=1:
//      - 4096 tuples with a clean 4'hF->4'h0 wrap at every level.
//      - DONE after tuple (15,15,15). IDX reads 0 in DONE.
//   5. Abort:
//      - CLR=1 at tuple 10: IDLE on the next cycle, IDX=0, BUSY=0, no DONE.
//      - Separately, RST=0 asynchronously mid-RUN: outputs go to 0 before the next CLK edge.
//      - Restart with START: the sequence begins from 0.
//   6. START re-asserted and LIMIT changed to {3,3,3} during RUN:
//      - Both are ignored; the sweep completes with the original 24 tuples.
//      - START in the IDLE cycle after DONE begins a 64-tuple sweep.

Source files
------------

// File: rtl/loop_index_counter_if.sv
// Control/status bundle for the nested-loop index generator.
// The master drives sweep control; the slave (the counter) returns the index tuple.
interface loop_index_counter_if #(
    parameter int NUM_LEVELS = 3,
    parameter int CNT_WIDTH  = 4
);
    logic                           CLR;
    logic                           START;
    logic                           CE;
    logic [NUM_LEVELS*CNT_WIDTH-1:0] LIMIT;
    logic                           BUSY;
    logic                           VALID;
    logic [NUM_LEVELS*CNT_WIDTH-1:0] IDX;
    logic [NUM_LEVELS-1:0]          WRAP;
    logic                           LAST;
    logic                           DONE;

    modport master (
        output CLR, START, CE, LIMIT,
        input  BUSY, VALID, IDX, WRAP, LAST, DONE
    );

    modport slave (
        input  CLR, START, CE, LIMIT,
        output BUSY, VALID, IDX, WRAP, LAST, DONE
    );
endinterface

// File: rtl/loop_index_counter.sv
// Nested-loop index generator: NUM_LEVELS chained counters, level 0 innermost,
// with per-level limits latched at START and a start/run/done sequencer.

module loop_index_level #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clr,
    input  logic         adv,
    input  logic [W-1:0] lim_in,
    output logic [W-1:0] idx,
    output logic         at_lim,
    output logic         carry
);
    logic [W-1:0] lim_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lim_q <= '0;
            idx   <= '0;
        end else begin
            if (load) lim_q <= lim_in;
            if (clr)      idx <= '0;
            else if (adv) idx <= at_lim ? '0 : idx + W'(1);
        end
    end

    assign at_lim = (idx == lim_q);
    assign carry  = adv & at_lim;
endmodule

module loop_index_counter #(
    parameter int NUM_LEVELS = 3,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    loop_index_counter_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_nx;
    logic   busy, valid, done;
    logic   start_acc, clr_idx;
    logic [NUM_LEVELS-1:0][CNT_WIDTH-1:0] lim, idx;
    logic [NUM_LEVELS-1:0]                at_lim;
    logic [NUM_LEVELS:0]                  carry;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.CLR) state_nx = S_IDLE;
        else begin
            case (state)
                S_IDLE:  if (bus.START) state_nx = S_RUN;
                S_RUN:   if (bus.CE && bus.LAST) state_nx = S_DONE;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = 1'b0;
        valid = 1'b0;
        done  = 1'b0;
        case (state)
            S_RUN:   begin busy = 1'b1; valid = 1'b1; end
            S_DONE:  begin busy = 1'b1; done  = 1'b1; end
            default: ;
        endcase
    end

    assign start_acc = (state == S_IDLE) & bus.START & ~bus.CLR;
    // The final advance already wraps every level to 0, so only abort/start need a forced clear.
    assign clr_idx   = bus.CLR | start_acc;
    assign lim       = bus.LIMIT;
    assign carry[0]  = valid & bus.CE;

    for (genvar i = 0; i < NUM_LEVELS; i++) begin : g_lvl
        loop_index_level #(.W(CNT_WIDTH)) u_lvl (
            .clk    (CLK),
            .rst_n  (RST),
            .load   (start_acc),
            .clr    (clr_idx),
            .adv    (carry[i]),
            .lim_in (lim[i]),
            .idx    (idx[i]),
            .at_lim (at_lim[i]),
            .carry  (carry[i+1])
        );
    end

    assign bus.BUSY  = busy;
    assign bus.VALID = valid;
    assign bus.DONE  = done;
    assign bus.IDX   = idx;
    assign bus.WRAP  = carry[NUM_LEVELS:1];
    assign bus.LAST  = valid & (&at_lim);
endmodule
